mem_arb16: RTL and testbench

MEM_ARB16 -- requirements
Module: mem_arb16

---
 rtl/mem_arb16.sv | 124 ++++++++++++
 tb/tb_mem_arb16.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb16.sv
// Arbiter between instruction fetch and data access on one single-port memory.
// Latency: the grant is combinational in the request cycle; the response arrives one cycle later.
// Backpressure: the losing requester sees no grant; a starved fetch is forced to win after STARVE_MAX denials.
module mem_arb16 #(
    parameter int STARVE_MAX = 3,
    parameter int AW         = 16
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [15:0]   if_rdata,
    output logic          if_valid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [15:0]   dm_wdata,
    output logic          dm_gnt,
    output logic [15:0]   dm_rdata,
    output logic          dm_valid,
    input  logic          hlt,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    output logic          fetch_stall,
    output logic [1:0]    state
);

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DATA   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t        cur_state;
    logic [SW-1:0] starve_cnt;
    logic          if_pend;
    logic          dm_pend;
    logic          dm_pend_wr;
    logic          starved;

    assign starved = (starve_cnt == SMAX);

    // Fixed-priority grant: halt blocks fetch, a starved fetch beats data, then data beats fetch.
    // Gated by rst_n so that every output is quiet while reset is held.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (rst_n) begin
            if (hlt) begin
                dm_gnt = dm_req;
            end else if (if_req && starved) begin
                if_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end else begin
                if_gnt = if_req;
            end
        end
    end

    // Steer the shared memory port from the granted requester; everything idles at zero otherwise.
    always_comb begin
        mem_en    = if_gnt | dm_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (dm_gnt) begin
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end
    end

    assign fetch_stall = rst_n & if_req & ~if_gnt;
    assign if_valid    = if_pend;
    assign dm_valid    = dm_pend;
    // Read data is only exposed alongside its valid; write acknowledgements carry zero data.
    assign if_rdata    = if_pend ? mem_rdata : 16'h0000;
    assign dm_rdata    = (dm_pend && !dm_pend_wr) ? mem_rdata : 16'h0000;
    assign state       = cur_state;

    // FSM tracks last cycle's owner, starvation counter and the one-cycle response pipeline.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= S_IDLE;
            starve_cnt <= '0;
            if_pend    <= 1'b0;
            dm_pend    <= 1'b0;
            dm_pend_wr <= 1'b0;
        end else begin
            if_pend    <= if_gnt;
            dm_pend    <= dm_gnt;
            dm_pend_wr <= dm_gnt & dm_we;

            // While halted a denied fetch is not counted as starving; the counter just holds.
            if (!if_req || if_gnt) begin
                starve_cnt <= '0;
            end else if (!hlt && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (if_gnt) begin
                cur_state <= S_FETCH;
            end else if (dm_gnt) begin
                cur_state <= S_DATA;
            end else if (hlt) begin
                cur_state <= S_HALTED;
            end else begin
                cur_state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_arb16.sv
// Self-checking bench for mem_arb16: table of per-cycle vectors plus a response scoreboard.
// Latency: responses are expected exactly one cycle after each expected grant.
// Backpressure: grant and stall expectations are hand-derived per vector.
module tb_mem_arb16;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_gnt;
    logic [15:0] dm_rdata;
    logic        dm_valid;
    logic        hlt;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        fetch_stall;
    logic [1:0]  state;

    mem_arb16 #(.STARVE_MAX(3), .AW(16)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .hlt(hlt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fetch_stall(fetch_stall), .state(state)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic        ir;
        logic [15:0] ia;
        logic        dr;
        logic        dw;
        logic [15:0] da;
        logic [15:0] dd;
        logic        h;
        logic [15:0] rd;
        logic        eig;
        logic        edg;
        logic [1:0]  est;
    } vec_t;

    typedef struct {
        logic is_if;
        logic is_wr;
        int   due;
    } rsp_t;

    localparam int NV = 27;
    vec_t vecs [NV];
    rsp_t sb [$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    function automatic vec_t mk(input logic ir, input logic [15:0] ia, input logic dr,
                                input logic dw, input logic [15:0] da, input logic [15:0] dd,
                                input logic h, input logic [15:0] rd, input logic eig,
                                input logic edg, input logic [1:0] est);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.h = h; v.rd = rd; v.eig = eig; v.edg = edg; v.est = est;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // One table row: drive at the falling edge, check 1ns later, then queue the expected response.
    task automatic step(input int idx, input vec_t v);
        logic ev_if;
        logic ev_dm;
        logic ewr;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        rsp_t r;
        @(negedge clk1);
        if_req = v.ir; if_addr = v.ia; dm_req = v.dr; dm_we = v.dw;
        dm_addr = v.da; dm_wdata = v.dd; hlt = v.h; mem_rdata = v.rd;
        #1;
        ev_if = 1'b0; ev_dm = 1'b0; ewr = 1'b0;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            r = sb.pop_front();
            chk("sb_stale", idx, 32'(r.due), 32'(cyc));
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            r = sb.pop_front();
            ev_if = r.is_if;
            ev_dm = !r.is_if;
            ewr   = r.is_wr;
        end
        e_addr  = v.eig ? v.ia : (v.edg ? v.da : 16'h0000);
        e_wdata = v.edg ? v.dd : 16'h0000;
        chk("if_gnt",      idx, 32'(if_gnt),      32'(v.eig));
        chk("dm_gnt",      idx, 32'(dm_gnt),      32'(v.edg));
        chk("mem_en",      idx, 32'(mem_en),      32'(v.eig | v.edg));
        chk("mem_we",      idx, 32'(mem_we),      32'(v.edg & v.dw));
        chk("mem_addr",    idx, 32'(mem_addr),    32'(e_addr));
        chk("mem_wdata",   idx, 32'(mem_wdata),   32'(e_wdata));
        chk("fetch_stall", idx, 32'(fetch_stall), 32'(v.ir & ~v.eig));
        chk("state",       idx, 32'(state),       32'(v.est));
        chk("if_valid",    idx, 32'(if_valid),    32'(ev_if));
        chk("if_rdata",    idx, 32'(if_rdata),    32'(ev_if ? v.rd : 16'h0000));
        chk("dm_valid",    idx, 32'(dm_valid),    32'(ev_dm));
        chk("dm_rdata",    idx, 32'(dm_rdata),    32'((ev_dm && !ewr) ? v.rd : 16'h0000));
        if (v.eig) sb.push_back('{1'b1, 1'b0, cyc + 1});
        if (v.edg) sb.push_back('{1'b0, v.dw, cyc + 1});
        cyc++;
    endtask

    initial begin
        // Single fetch, data write, data read
        vecs[0]  = mk(1, 16'h0004, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 2'd0);
        vecs[1]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'hA1B2, 0, 0, 2'd1);
        vecs[2]  = mk(0, 16'h0000, 1, 1, 16'h0010, 16'h1234, 0, 16'h0000, 0, 1, 2'd0);
        vecs[3]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h5555, 0, 0, 2'd2);
        vecs[4]  = mk(0, 16'h0000, 1, 0, 16'h0020, 16'h0000, 0, 16'h0000, 0, 1, 2'd0);
        // Conflict: data wins three times, then the starved fetch is forced through
        vecs[5]  = mk(1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 0, 16'h7777, 0, 1, 2'd2);
        vecs[6]  = mk(1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 0, 16'h1111, 0, 1, 2'd2);
        vecs[7]  = mk(1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 0, 16'h2222, 0, 1, 2'd2);
        vecs[8]  = mk(1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 0, 16'h3333, 1, 0, 2'd2);
        vecs[9]  = mk(1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 0, 16'h4444, 0, 1, 2'd1);
        vecs[10] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h5A5A, 0, 0, 2'd2);
        // Halt with fetch pending: no grant, HALTED, then data still granted
        vecs[11] = mk(1, 16'h0300, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 0, 2'd0);
        vecs[12] = mk(1, 16'h0300, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 0, 2'd3);
        vecs[13] = mk(1, 16'h0300, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 0, 2'd3);
        vecs[14] = mk(1, 16'h0300, 1, 0, 16'h0400, 16'h0000, 1, 16'h0000, 0, 1, 2'd3);
        // Counter stayed 0 during halt, so data still beats fetch here
        vecs[15] = mk(1, 16'h0300, 1, 0, 16'h0404, 16'h0000, 0, 16'h9999, 0, 1, 2'd2);
        // Alternating fetch/data back to back
        vecs[16] = mk(1, 16'h0500, 0, 0, 16'h0000, 16'h0000, 0, 16'h8888, 1, 0, 2'd2);
        vecs[17] = mk(0, 16'h0000, 1, 0, 16'h0600, 16'h0000, 0, 16'h1357, 0, 1, 2'd1);
        vecs[18] = mk(1, 16'h0700, 0, 0, 16'h0000, 16'h0000, 0, 16'h2468, 1, 0, 2'd2);
        vecs[19] = mk(0, 16'h0000, 1, 1, 16'h0800, 16'hBEEF, 0, 16'h3579, 0, 1, 2'd1);
        vecs[20] = mk(1, 16'h0900, 0, 0, 16'h0000, 16'h0000, 0, 16'h4680, 1, 0, 2'd2);
        vecs[21] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0F0F, 0, 0, 2'd1);
        vecs[22] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 2'd0);
        // Halt rising while a fetch response is outstanding
        vecs[23] = mk(1, 16'h0A00, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 2'd0);
        vecs[24] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'hCAFE, 0, 0, 2'd1);
        vecs[25] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 2'd3);
        vecs[26] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 2'd0);

        // Reset with requests present: every output must be quiet
        rst_n = 1'b0; if_req = 1'b1; if_addr = 16'h1111; dm_req = 1'b1; dm_we = 1'b1;
        dm_addr = 16'h2222; dm_wdata = 16'h3333; hlt = 1'b0; mem_rdata = 16'hFFFF;
        repeat (2) @(posedge clk1);
        #1;
        chk("rst_if_gnt",   -1, 32'(if_gnt),      32'd0);
        chk("rst_dm_gnt",   -1, 32'(dm_gnt),      32'd0);
        chk("rst_mem_en",   -1, 32'(mem_en),      32'd0);
        chk("rst_mem_addr", -1, 32'(mem_addr),    32'd0);
        chk("rst_stall",    -1, 32'(fetch_stall), 32'd0);
        chk("rst_state",    -1, 32'(state),       32'd0);
        chk("rst_if_rdata", -1, 32'(if_rdata),    32'd0);
        @(negedge clk1);
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; rst_n = 1'b1;

        for (int i = 0; i < NV; i++) step(i, vecs[i]);

        // Reset asserted between a fetch grant and its response edge
        @(negedge clk1);
        if_req = 1'b1; if_addr = 16'h0B00; mem_rdata = 16'h0000;
        #1;
        chk("mid_if_gnt", 100, 32'(if_gnt), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_if_gnt",   100, 32'(if_gnt),      32'd0);
        chk("mid_rst_mem_en",   100, 32'(mem_en),      32'd0);
        chk("mid_rst_mem_addr", 100, 32'(mem_addr),    32'd0);
        chk("mid_rst_stall",    100, 32'(fetch_stall), 32'd0);
        @(posedge clk1);
        #1;
        chk("mid_rst_if_valid", 101, 32'(if_valid), 32'd0);
        chk("mid_rst_state",    101, 32'(state),    32'd0);
        @(negedge clk1);
        if_req = 1'b0; mem_rdata = 16'h7E7E; rst_n = 1'b1;
        #1;
        chk("rel_if_valid", 102, 32'(if_valid), 32'd0);
        chk("rel_state",    102, 32'(state),    32'd0);
        @(negedge clk1);
        #1;
        chk("rel2_if_valid", 103, 32'(if_valid), 32'd0);
        chk("rel2_state",    103, 32'(state),    32'd0);
        // Arbitration resumes right after release
        if_req = 1'b1; if_addr = 16'h0C00;
        #1;
        chk("resume_if_gnt",   104, 32'(if_gnt),   32'd1);
        chk("resume_mem_addr", 104, 32'(mem_addr), 32'h0C00);
        @(negedge clk1);
        if_req = 1'b0; mem_rdata = 16'h1F2E;
        #1;
        chk("resume_if_valid", 105, 32'(if_valid), 32'd1);
        chk("resume_if_rdata", 105, 32'(if_rdata), 32'h1F2E);
        chk("resume_state",    105, 32'(state),    32'd1);

        chk("sb_drained", 106, 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
